// File: rtl/cdb_arbiter_buf_pkg.sv
// Shared definitions for the CDB arbiter: default source/lane counts derived from
// the functional-unit mix, default field widths, priority encodings and the CDB packet.
package cdb_arbiter_buf_pkg;

  localparam int NUM_ALU       = 4;
  localparam int NUM_MULT      = 2;
  localparam int NUM_MEM       = 2;
  localparam int NUM_SRC_DEF   = NUM_ALU + NUM_MULT + NUM_MEM;
  localparam int NUM_CDB_DEF   = 3;
  localparam int PRF_IDX_W_DEF = 6;
  localparam int ROB_IDX_W_DEF = 5;
  localparam int DATA_W_DEF    = 32;

  typedef enum logic [0:0] {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  typedef struct packed {
    logic                     valid;
    logic [PRF_IDX_W_DEF-1:0] prf_idx;
    logic [ROB_IDX_W_DEF-1:0] rob_idx;
    logic [DATA_W_DEF-1:0]    value;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_buf_if.sv
// Result-source and broadcast-bus bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_buf_if #(
  parameter int NUM_SRC   = 8,
  parameter int NUM_CDB   = 3,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
);
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*PRF_IDX_W-1:0] src_prf_idx;
  logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx;
  logic [NUM_SRC*DATA_W-1:0]    src_value;
  logic [NUM_SRC-1:0]           src_ready;
  logic                         squash;
  logic [NUM_CDB-1:0]           cdb_valid;
  logic [NUM_CDB*PRF_IDX_W-1:0] cdb_prf_idx;
  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_idx;
  logic [NUM_CDB*DATA_W-1:0]    cdb_value;
  logic [31:0]                  conflict_cnt;

  modport master (
    output src_valid, src_prf_idx, src_rob_idx, src_value, squash,
    input  src_ready, cdb_valid, cdb_prf_idx, cdb_rob_idx, cdb_value, conflict_cnt
  );

  modport slave (
    input  src_valid, src_prf_idx, src_rob_idx, src_value, squash,
    output src_ready, cdb_valid, cdb_prf_idx, cdb_rob_idx, cdb_value, conflict_cnt
  );
endinterface

// File: rtl/cdb_arbiter_buf_src_fifo.sv
// Per-source skid FIFO: circular buffer with combinational head, registered count and ready.
module cdb_src_fifo #(
  parameter int  BUF_DEPTH = 2,
  parameter int  ENTRY_W   = 43,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               ready
);

  logic [ENTRY_W-1:0] mem_reg [BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready looks only at the registered count, so a full FIFO stays closed even while popping.
  assign ready   = (count_reg < CNT_W'(BUF_DEPTH));
  assign do_push = push & ready & ~clear;
  assign do_pop  = pop & (count_reg != '0) & ~clear;
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/cdb_arbiter_buf.sv
// Buffers FU results per source and broadcasts up to NUM_CDB of them per cycle on the CDB,
// with fixed or round-robin source priority, squash flush and a saturating conflict counter.
module cdb_arbiter_buf
  import cdb_arbiter_buf_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int NUM_CDB   = NUM_CDB_DEF,
  parameter int BUF_DEPTH = 2,
  parameter int PRF_IDX_W = PRF_IDX_W_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PRIO_MODE = int'(PRIO_RR)
) (
  input  logic           clock,
  input  logic           reset,
  cdb_arbiter_buf_if.slave bus
);

  localparam int ENTRY_W = PRF_IDX_W + ROB_IDX_W + DATA_W;
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

  logic [ENTRY_W-1:0] din  [NUM_SRC];
  logic [ENTRY_W-1:0] head [NUM_SRC];
  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [NUM_SRC-1:0] ready, push, grant, nonempty;

  logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [31:0]        conflict_cnt_reg;
  logic [SRC_W-1:0]   lane_sel [NUM_CDB];
  logic [NUM_CDB-1:0] lane_vld;
  int                 n_nonempty;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign din[gi] = {bus.src_prf_idx[gi*PRF_IDX_W +: PRF_IDX_W],
                        bus.src_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W],
                        bus.src_value[gi*DATA_W +: DATA_W]};
      assign push[gi]     = bus.src_valid[gi] & ready[gi] & ~bus.squash;
      assign nonempty[gi] = (count[gi] != '0);

      cdb_src_fifo #(.BUF_DEPTH(BUF_DEPTH), .ENTRY_W(ENTRY_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push[gi]),
        .pop   (grant[gi]),
        .clear (bus.squash),
        .din   (din[gi]),
        .head  (head[gi]),
        .count (count[gi]),
        .ready (ready[gi])
      );
    end
  endgenerate

  assign bus.src_ready = ready;

  // Scan sources from the start point; the n-th non-empty source found takes lane n.
  always_comb begin
    int unsigned      start;
    int unsigned      used;
    logic [SRC_W-1:0] idx;
    grant       = '0;
    lane_vld    = '0;
    rr_ptr_next = rr_ptr_reg;
    n_nonempty  = 0;
    used        = 0;
    idx         = '0;
    for (int k = 0; k < NUM_CDB; k++) lane_sel[k] = '0;
    start = (PRIO_MODE == int'(PRIO_RR)) ? int'(rr_ptr_reg) : 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = SRC_W'((start + j) % NUM_SRC);
      if (nonempty[idx]) begin
        n_nonempty = n_nonempty + 1;
        if (!bus.squash && used < NUM_CDB) begin
          for (int k = 0; k < NUM_CDB; k++) begin
            if (used == k) begin
              lane_vld[k] = 1'b1;
              lane_sel[k] = idx;
            end
          end
          grant[idx]  = 1'b1;
          used        = used + 1;
          rr_ptr_next = SRC_W'((int'(idx) + 1) % NUM_SRC);
        end
      end
    end
  end

  always_comb begin
    logic [ENTRY_W-1:0] ld;
    bus.cdb_valid   = lane_vld;
    bus.cdb_prf_idx = '0;
    bus.cdb_rob_idx = '0;
    bus.cdb_value   = '0;
    ld              = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      ld = lane_vld[k] ? head[lane_sel[k]] : '0;
      bus.cdb_prf_idx[k*PRF_IDX_W +: PRF_IDX_W] = ld[ENTRY_W-1 -: PRF_IDX_W];
      bus.cdb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] = ld[DATA_W +: ROB_IDX_W];
      bus.cdb_value[k*DATA_W +: DATA_W]         = ld[DATA_W-1:0];
    end
  end

  // Squash freezes both the rotation point and the conflict statistic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg       <= '0;
      conflict_cnt_reg <= '0;
    end else if (!bus.squash) begin
      if (PRIO_MODE == int'(PRIO_RR)) rr_ptr_reg <= rr_ptr_next;
      if (n_nonempty > NUM_CDB && conflict_cnt_reg != '1)
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign bus.conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_cdb_arbiter_buf.sv
// Bench for cdb_arbiter_buf: fixed-priority and round-robin instances share directed stimulus
// and are checked every cycle against a queue-based model plus hand-computed expectations.
module tb_cdb_arbiter_buf;
  import cdb_arbiter_buf_pkg::*;

  localparam int NS = 8;
  localparam int NC = 3;
  localparam int DEPTH = 2;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS*PW-1:0] src_prf = '0;
  logic [NS*RW-1:0] src_rob = '0;
  logic [NS*DW-1:0] src_value = '0;
  logic             squash = 1'b0;
  int               cyc_no = 0;
  int               n_checks = 0;
  int               n_pass = 0;
  int               load_req = 0;
  logic             collect4 = 1'b0;
  logic [PW-1:0]    seen4 [$];

  always #5 clock = ~clock;

  cdb_arbiter_buf_if #(.NUM_SRC(NS), .NUM_CDB(NC), .PRF_IDX_W(PW), .ROB_IDX_W(RW), .DATA_W(DW)) if0 ();
  cdb_arbiter_buf_if #(.NUM_SRC(NS), .NUM_CDB(NC), .PRF_IDX_W(PW), .ROB_IDX_W(RW), .DATA_W(DW)) if1 ();

  assign if0.src_valid = src_valid;   assign if1.src_valid = src_valid;
  assign if0.src_prf_idx = src_prf;   assign if1.src_prf_idx = src_prf;
  assign if0.src_rob_idx = src_rob;   assign if1.src_rob_idx = src_rob;
  assign if0.src_value = src_value;   assign if1.src_value = src_value;
  assign if0.squash = squash;         assign if1.squash = squash;

  cdb_arbiter_buf #(.NUM_SRC(NS), .NUM_CDB(NC), .BUF_DEPTH(DEPTH), .PRF_IDX_W(PW),
                    .ROB_IDX_W(RW), .DATA_W(DW), .PRIO_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave));
  cdb_arbiter_buf #(.NUM_SRC(NS), .NUM_CDB(NC), .BUF_DEPTH(DEPTH), .PRF_IDX_W(PW),
                    .ROB_IDX_W(RW), .DATA_W(DW), .PRIO_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .bus(if1.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model: one queue per source per instance ----------------
  cdb_packet_t      mq [2*NS][$];
  int unsigned      m_rr [2];
  logic [31:0]      m_cnt [2];
  int               load_ack = 0;
  logic [NC-1:0]    e_valid, a_valid;
  logic [42:0]      e_lane [NC];
  logic [42:0]      a_lane [NC];
  logic [NS-1:0]    e_ready, a_ready;
  logic [31:0]      a_cnt;
  logic [NC*PW-1:0] a_prf;
  logic [NC*RW-1:0] a_rob;
  logic [NC*DW-1:0] a_val;
  int               gsrc [NC];
  int               used, ne, s;
  cdb_packet_t      pk;

  always @(negedge clock) begin
    for (int m = 0; m < 2; m++) begin
      e_valid = '0;
      e_ready = '1;
      used = 0;
      ne = 0;
      for (int k = 0; k < NC; k++) begin e_lane[k] = '0; gsrc[k] = 0; end
      if (!reset) begin
        for (int i = 0; i < NS; i++) mq[m*NS+i].delete();
        m_rr[m] = 0;
        m_cnt[m] = '0;
      end else begin
        if (load_req != load_ack) m_cnt[m] = 32'hFFFF_FFFE;
        for (int i = 0; i < NS; i++) begin
          e_ready[i] = (mq[m*NS+i].size() < DEPTH);
          if (mq[m*NS+i].size() > 0) ne++;
        end
        if (!squash) begin
          for (int j = 0; j < NS; j++) begin
            s = (((m == 1) ? int'(m_rr[m]) : 0) + j) % NS;
            if (mq[m*NS+s].size() > 0 && used < NC) begin
              pk = mq[m*NS+s][0];
              e_valid[used] = 1'b1;
              e_lane[used] = {pk.prf_idx, pk.rob_idx, pk.value};
              gsrc[used] = s;
              used++;
            end
          end
        end
      end
      if (m == 0) begin
        a_valid = if0.cdb_valid; a_ready = if0.src_ready; a_cnt = if0.conflict_cnt;
        a_prf = if0.cdb_prf_idx; a_rob = if0.cdb_rob_idx; a_val = if0.cdb_value;
      end else begin
        a_valid = if1.cdb_valid; a_ready = if1.src_ready; a_cnt = if1.conflict_cnt;
        a_prf = if1.cdb_prf_idx; a_rob = if1.cdb_rob_idx; a_val = if1.cdb_value;
      end
      for (int k = 0; k < NC; k++) a_lane[k] = {a_prf[k*PW +: PW], a_rob[k*RW +: RW], a_val[k*DW +: DW]};
      chk($sformatf("cyc%0d dut%0d cdb_valid", cyc_no, m), 64'(a_valid), 64'(e_valid));
      for (int k = 0; k < NC; k++)
        chk($sformatf("cyc%0d dut%0d lane%0d", cyc_no, m, k), 64'(a_lane[k]), 64'(e_lane[k]));
      chk($sformatf("cyc%0d dut%0d src_ready", cyc_no, m), 64'(a_ready), 64'(e_ready));
      chk($sformatf("cyc%0d dut%0d conflict_cnt", cyc_no, m), 64'(a_cnt), 64'(m_cnt[m]));
      if (m == 0 && collect4)
        for (int k = 0; k < NC; k++)
          if (a_valid[k] && a_rob[k*RW +: RW] == 5'd4) seen4.push_back(a_prf[k*PW +: PW]);
      // advance to the state after the coming clock edge
      if (reset) begin
        if (squash) begin
          for (int i = 0; i < NS; i++) mq[m*NS+i].delete();
        end else begin
          for (int k = 0; k < used; k++) void'(mq[m*NS+gsrc[k]].pop_front());
          if (ne > NC && m_cnt[m] != 32'hFFFF_FFFF) m_cnt[m] = m_cnt[m] + 32'd1;
          if (m == 1 && used > 0) m_rr[m] = (gsrc[used-1] + 1) % NS;
          for (int i = 0; i < NS; i++)
            if (src_valid[i] && e_ready[i])
              mq[m*NS+i].push_back('{valid: 1'b1, prf_idx: src_prf[i*PW +: PW],
                                     rob_idx: src_rob[i*RW +: RW], value: src_value[i*DW +: DW]});
        end
      end
    end
    load_ack = load_req;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [NS-1:0] v, input logic sq, input logic rn, input logic [PW-1:0] tag4);
    @(posedge clock);
    #1;
    cyc_no++;
    reset = rn;
    squash = sq;
    src_valid = v;
    for (int i = 0; i < NS; i++) begin
      src_prf[i*PW +: PW] = (i == 4) ? tag4 : PW'(i + 16);
      src_rob[i*RW +: RW] = RW'(i);
      src_value[i*DW +: DW] = 32'(cyc_no * 256 + i);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b1, 6'd20);
  endtask

  initial begin
    int ok;
    // reset state
    cyc('0, 1'b0, 1'b0, 6'd20);
    cyc('0, 1'b0, 1'b0, 6'd20);
    chk("reset cdb_valid", 64'(if0.cdb_valid), 64'd0);
    chk("reset src_ready", 64'(if1.src_ready), 64'hFF);
    idle(2);

    // fixed priority: sources 0,2,5,7 push together
    cyc(8'hA5, 1'b0, 1'b1, 6'd20);
    cyc('0, 1'b0, 1'b1, 6'd20);
    chk("t2 lanes valid", 64'(if0.cdb_valid), 64'b111);
    chk("t2 lanes src", 64'(if0.cdb_rob_idx), 64'({5'd5, 5'd2, 5'd0}));
    cyc('0, 1'b0, 1'b1, 6'd20);
    chk("t2 tail valid", 64'(if0.cdb_valid), 64'b001);
    chk("t2 tail src", 64'(if0.cdb_rob_idx), 64'({5'd0, 5'd0, 5'd7}));
    chk("t2 conflict", 64'(if0.conflict_cnt), 64'd1);
    idle(2);

    // round robin: all sources continuously valid
    cyc(8'hFF, 1'b0, 1'b1, 6'd20);
    cyc(8'hFF, 1'b0, 1'b1, 6'd20);
    chk("t3 rr set0", 64'(if1.cdb_rob_idx), 64'({5'd2, 5'd1, 5'd0}));
    cyc(8'hFF, 1'b0, 1'b1, 6'd20);
    chk("t3 rr set1", 64'(if1.cdb_rob_idx), 64'({5'd5, 5'd4, 5'd3}));
    cyc(8'hFF, 1'b0, 1'b1, 6'd20);
    chk("t3 rr set2", 64'(if1.cdb_rob_idx), 64'({5'd0, 5'd7, 5'd6}));
    cyc(8'hFF, 1'b0, 1'b1, 6'd20);
    chk("t3 rr set3", 64'(if1.cdb_rob_idx), 64'({5'd3, 5'd2, 5'd1}));
    chk("t3 conflict", 64'(if1.conflict_cnt), 64'd4);
    idle(8);

    // back-pressure on source 4 while sources 0-3 saturate the lanes
    collect4 = 1'b1;
    cyc(8'h1F, 1'b0, 1'b1, 6'd10);
    cyc(8'h1F, 1'b0, 1'b1, 6'd11);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h1F, 1'b0, 1'b1, 6'd12);
      chk("t4 ready4 low", 64'(if0.src_ready[4]), 64'd0);
    end
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      cyc(8'h10, 1'b0, 1'b1, 6'd12);
      if (if0.src_ready[4]) ok = 1;
    end
    chk("t4 tag12 accepted in bound", 64'(ok), 64'd1);
    idle(8);
    collect4 = 1'b0;
    chk("t4 count", 64'(seen4.size()), 64'd3);
    if (seen4.size() == 3)
      chk("t4 order", 64'({seen4[0], seen4[1], seen4[2]}), 64'({6'd10, 6'd11, 6'd12}));

    // squash with 5 buffered and 2 incoming
    cyc(8'hFF, 1'b0, 1'b1, 6'd20);
    cyc('0, 1'b0, 1'b1, 6'd20);
    cyc(8'h03, 1'b1, 1'b1, 6'd20);
    chk("t5 squash valid", 64'({if0.cdb_valid, if1.cdb_valid}), 64'd0);
    cyc('0, 1'b0, 1'b1, 6'd20);
    chk("t5 ready after", 64'({if0.src_ready, if1.src_ready}), 64'hFFFF);
    chk("t5 idle after", 64'({if0.cdb_valid, if1.cdb_valid}), 64'd0);
    idle(4);

    // asynchronous reset with buffered traffic
    cyc(8'h3F, 1'b0, 1'b1, 6'd20);
    cyc('0, 1'b0, 1'b1, 6'd20);
    cyc('0, 1'b0, 1'b0, 6'd20);
    chk("t6 rst valid", 64'({if0.cdb_valid, if1.cdb_valid}), 64'd0);
    chk("t6 rst cnt", 64'({if0.conflict_cnt, if1.conflict_cnt}), 64'd0);
    chk("t6 rst ready", 64'({if0.src_ready, if1.src_ready}), 64'hFFFF);
    cyc(8'h40, 1'b0, 1'b1, 6'd20);
    cyc('0, 1'b0, 1'b1, 6'd20);
    chk("t6 first valid", 64'(if0.cdb_valid), 64'b001);
    chk("t6 first src", 64'(if1.cdb_rob_idx[RW-1:0]), 64'd6);
    idle(2);

    // counter saturation
    cyc(8'h0F, 1'b0, 1'b1, 6'd20);
    @(posedge clock);
    #1;
    force dut0.conflict_cnt_reg = 32'hFFFF_FFFE;
    force dut1.conflict_cnt_reg = 32'hFFFF_FFFE;
    load_req++;
    #1;
    release dut0.conflict_cnt_reg;
    release dut1.conflict_cnt_reg;
    cyc_no++;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h0F, 1'b0, 1'b1, 6'd20);
      chk("t7 saturated", 64'(if0.conflict_cnt), 64'hFFFF_FFFF);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
